// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Package : md_pkg
// Brief   : Shared types and constants for the multiply/divide sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package md_pkg;

   // Sequencer state encoding (explicit 2-bit width)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } md_state_t;

   // Operation select as seen on issue_op
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Default wait limit for the unit's result-ready, and the counter width
   // that holds it (TIMEOUT_CYC must not exceed 2**CNT_W)
   localparam int TIMEOUT_CYC_DEFAULT = 40;
   localparam int CNT_W               = 6;

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : md_timeout_counter
// Brief   : Up-counter with synchronous clear/enable and a terminal-count flag,
//           used to bound the wait for the multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
module md_timeout_counter
   import md_pkg::*;
#(
   parameter int WIDTH    = CNT_W,
   parameter int TERMINAL = TIMEOUT_CYC_DEFAULT - 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [WIDTH-1:0] count;

   // Count register: clear has priority over enable
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == WIDTH'(TERMINAL));

endmodule : md_timeout_counter
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_sequencer
// Brief   : Issue/retire controller for the shared multi-cycle multiply/divide
//           unit. Latches one op, pulses the unit start, waits for result-ready
//           (bounded by a timeout), then holds the result for writeback.
// Revision: 1.0 - initial release
// ============================================================================
module multdiv_sequencer
   import md_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int RD_W        = 5,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   // issue side
   input  logic              issue_valid,
   input  logic              issue_op,
   input  logic [DATA_W-1:0] issue_a,
   input  logic [DATA_W-1:0] issue_b,
   input  logic [RD_W-1:0]   issue_rd,
   output logic              issue_ready,
   input  logic              flush,
   // unit control
   output logic              md_ctrl_MULT,
   output logic              md_ctrl_DIV,
   output logic [DATA_W-1:0] md_operandA,
   output logic [DATA_W-1:0] md_operandB,
   input  logic [DATA_W-1:0] md_result,
   input  logic              md_exception,
   input  logic              md_resultRDY,
   // writeback side
   output logic              wb_valid,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_exception,
   input  logic              wb_ready,
   // hazard status
   output logic              busy,
   output logic [RD_W-1:0]   busy_rd
);

   md_state_t         state;
   md_state_t         state_next;

   logic              op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [RD_W-1:0]   rd_q;
   logic [DATA_W-1:0] data_q;
   logic              exc_q;

   logic              issue_fire;
   logic              capture;
   logic              cap_exc;
   logic              discard;
   logic              done_leave;
   logic              cnt_terminal;

   assign issue_fire = issue_valid & issue_ready;

   // A result is taken in RUN on the ready edge or when the wait expires;
   // a flush in the same cycle squashes it.
   assign capture    = (state == RUN) & ~flush & (md_resultRDY | cnt_terminal);

   // Timeout with no ready is reported as an exception with zero data
   assign cap_exc    = md_resultRDY ? md_exception : 1'b1;

   // Writes to x0 are dropped unless there is an exception to report
   assign discard    = (rd_q == '0) & ~cap_exc;

   // An x0 exception is shown for one cycle only; otherwise wait for writeback
   assign done_leave = wb_ready | (rd_q == '0);

   assign md_operandA = a_q;
   assign md_operandB = b_q;

   md_timeout_counter #(
      .WIDTH    (CNT_W),
      .TERMINAL (TIMEOUT_CYC - 1)
   ) u_timeout (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (state == START),
      .enable   (state == RUN),
      .terminal (cnt_terminal)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (issue_fire) begin
               state_next = START;
            end
         end
         START: begin
            state_next = flush ? IDLE : RUN;
         end
         RUN: begin
            if (flush) begin
               state_next = IDLE;
            end else if (capture) begin
               state_next = discard ? IDLE : DONE;
            end
         end
         DONE: begin
            if (done_leave) begin
               state_next = issue_fire ? START : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      issue_ready  = 1'b0;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      wb_exception = 1'b0;
      busy         = (state != IDLE);
      busy_rd      = '0;
      case (state)
         IDLE: begin
            issue_ready = ~flush;
         end
         START: begin
            // A flush here suppresses the pulse so the unit never starts
            md_ctrl_MULT = ~flush & (op_q == OP_MULT);
            md_ctrl_DIV  = ~flush & (op_q == OP_DIV);
            busy_rd      = rd_q;
         end
         RUN: begin
            busy_rd = rd_q;
         end
         DONE: begin
            issue_ready  = done_leave & ~flush;
            wb_valid     = 1'b1;
            wb_rd        = rd_q;
            wb_data      = data_q;
            wb_exception = exc_q;
            busy_rd      = rd_q;
         end
         default: ;
      endcase
   end

   // Issue latch: written only when an op is accepted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q <= OP_MULT;
         a_q  <= '0;
         b_q  <= '0;
         rd_q <= '0;
      end else if (issue_fire) begin
         op_q <= issue_op;
         a_q  <= issue_a;
         b_q  <= issue_b;
         rd_q <= issue_rd;
      end
   end

   // Result capture: written only on ready or timeout in RUN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
         exc_q  <= 1'b0;
      end else if (capture) begin
         data_q <= md_resultRDY ? md_result : '0;
         exc_q  <= cap_exc;
      end
   end

endmodule : multdiv_sequencer
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_multdiv_sequencer
// Brief   : Self-checking bench for multdiv_sequencer with a stub mult/div unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

   logic        clock;
   logic        reset_n;
   logic        issue_valid;
   logic        issue_op;
   logic [31:0] issue_a;
   logic [31:0] issue_b;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        flush;
   logic        md_ctrl_MULT;
   logic        md_ctrl_DIV;
   logic [31:0] md_operandA;
   logic [31:0] md_operandB;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exception;
   logic        wb_ready;
   logic        busy;
   logic [4:0]  busy_rd;

   int   total;
   int   bad;
   logic cur_op;

   multdiv_sequencer #(
      .DATA_W      (32),
      .RD_W        (5),
      .TIMEOUT_CYC (40)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .issue_op     (issue_op),
      .issue_a      (issue_a),
      .issue_b      (issue_b),
      .issue_rd     (issue_rd),
      .issue_ready  (issue_ready),
      .flush        (flush),
      .md_ctrl_MULT (md_ctrl_MULT),
      .md_ctrl_DIV  (md_ctrl_DIV),
      .md_operandA  (md_operandA),
      .md_operandB  (md_operandB),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_exception (wb_exception),
      .wb_ready     (wb_ready),
      .busy         (busy),
      .busy_rd      (busy_rd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          lat;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_exc;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Present one op in IDLE and confirm the single start pulse
   task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_a     = a;
      issue_b     = b;
      issue_rd    = rd;
      cur_op      = op;
      #1;
      check("issue_ready_idle", issue_ready, 1);
      tick();
      issue_valid = 1'b0;
      issue_a     = '0;
      issue_b     = '0;
      check("start_div", md_ctrl_DIV, op);
      check("start_mult", md_ctrl_MULT, !op);
      check("start_busy_rd", busy_rd, rd);
      check("start_opA", md_operandA, a);
      check("start_opB", md_operandB, b);
      tick();
      check("pulse_one_cycle", {md_ctrl_DIV, md_ctrl_MULT}, 2'b00);
   endtask

   // Stub unit: after lat cycles raise ready for one cycle with the result
   // computed from the operands the sequencer is presenting
   task automatic finish_op(input int lat);
      logic signed [63:0] prod;
      for (int i = 1; i < lat; i++) tick();
      if (cur_op == 1'b1) begin
         if (md_operandB == 32'd0) begin
            md_result    = 32'd0;
            md_exception = 1'b1;
         end else begin
            md_result    = $signed(md_operandA) / $signed(md_operandB);
            md_exception = 1'b0;
         end
      end else begin
         prod         = 64'($signed(md_operandA)) * 64'($signed(md_operandB));
         md_result    = prod[31:0];
         md_exception = (prod != {{32{prod[31]}}, prod[31:0]});
      end
      md_resultRDY = 1'b1;
      tick();
      md_resultRDY = 1'b0;
      md_result    = '0;
      md_exception = 1'b0;
   endtask

   task automatic handshake();
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      check("idle_after_wb", busy, 0);
      check("no_wb_after", wb_valid, 0);
   endtask

   initial begin
      int n;
      total        = 0;
      bad          = 0;
      cur_op       = 1'b0;
      reset_n      = 1'b0;
      issue_valid  = 1'b0;
      issue_op     = 1'b0;
      issue_a      = '0;
      issue_b      = '0;
      issue_rd     = '0;
      flush        = 1'b0;
      md_result    = '0;
      md_exception = 1'b0;
      md_resultRDY = 1'b0;
      wb_ready     = 1'b0;

      //             op    a             b            rd  lat valid data          exc
      vecs[0] = '{1'b1, 32'd100,      32'd7,       5'd3,  33, 1'b1, 32'd14,       1'b0};
      vecs[1] = '{1'b1, -32'sd20,     32'd0,       5'd4,  33, 1'b1, 32'd0,        1'b1};
      vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'd2,       5'd5,  4,  1'b1, 32'hFFFFFFFE, 1'b1};
      vecs[3] = '{1'b0, -32'sd3,      32'd5,       5'd31, 4,  1'b1, 32'hFFFFFFF1, 1'b0};
      vecs[4] = '{1'b1, -32'sd20,     32'd3,       5'd7,  33, 1'b1, 32'hFFFFFFFA, 1'b0};
      vecs[5] = '{1'b0, 32'd6,        32'd7,       5'd0,  4,  1'b0, 32'd0,        1'b0};
      vecs[6] = '{1'b1, 32'd5,        32'd0,       5'd0,  33, 1'b1, 32'd0,        1'b1};

      // Reset state
      #1;
      check("rst_issue_ready", issue_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
      check("rst_operandA", md_operandA, 0);
      #20;
      reset_n = 1'b1;
      tick();

      // Ready from the unit while idle is ignored
      md_resultRDY = 1'b1;
      md_result    = 32'hDEAD;
      tick();
      md_resultRDY = 1'b0;
      md_result    = '0;
      check("idle_rdy_busy", busy, 0);
      check("idle_rdy_wb", wb_valid, 0);

      // Table-driven ops
      foreach (vecs[k]) begin
         start_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].rd);
         finish_op(vecs[k].lat);
         check($sformatf("v%0d_wb_valid", k), wb_valid, vecs[k].exp_valid);
         if (vecs[k].exp_valid) begin
            check($sformatf("v%0d_wb_data", k), wb_data, vecs[k].exp_data);
            check($sformatf("v%0d_wb_exc", k), wb_exception, vecs[k].exp_exc);
            check($sformatf("v%0d_wb_rd", k), wb_rd, vecs[k].rd);
            check($sformatf("v%0d_busy_rd", k), busy_rd, vecs[k].rd);
         end else begin
            check($sformatf("v%0d_busy", k), busy, 0);
         end
         handshake();
      end

      // Writeback stall then back-to-back issue
      start_op(1'b0, 32'd9, 32'd9, 5'd2);
      finish_op(3);
      check("hold_valid0", wb_valid, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_data", {wb_valid, wb_rd, wb_exception, wb_data}, {1'b1, 5'd2, 1'b0, 32'd81});
      end
      wb_ready    = 1'b1;
      issue_valid = 1'b1;
      issue_op    = 1'b0;
      issue_a     = 32'd6;
      issue_b     = 32'd7;
      issue_rd    = 5'd6;
      cur_op      = 1'b0;
      #1;
      check("b2b_issue_ready", issue_ready, 1);
      tick();
      wb_ready    = 1'b0;
      issue_valid = 1'b0;
      check("b2b_start", {md_ctrl_MULT, md_ctrl_DIV}, 2'b10);
      check("b2b_busy_rd", busy_rd, 6);
      check("b2b_wb_clear", wb_valid, 0);
      tick();
      finish_op(3);
      check("b2b_data", wb_data, 42);
      check("b2b_rd", wb_rd, 6);
      handshake();

      // Flush in RUN cycle 5, later ready is ignored
      start_op(1'b1, 32'd100, 32'd7, 5'd3);
      for (int i = 0; i < 4; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_wb", wb_valid, 0);
      md_resultRDY = 1'b1;
      md_result    = 32'd14;
      tick();
      md_resultRDY = 1'b0;
      md_result    = '0;
      check("flush_late_rdy", {busy, wb_valid}, 2'b00);

      // Flush wins over issue in IDLE
      issue_valid = 1'b1;
      issue_op    = 1'b1;
      issue_rd    = 5'd8;
      flush       = 1'b1;
      #1;
      check("flush_idle_ready", issue_ready, 0);
      tick();
      issue_valid = 1'b0;
      flush       = 1'b0;
      check("flush_idle_busy", busy, 0);
      check("flush_idle_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);

      // Timeout with a unit that never answers
      start_op(1'b0, 32'd1, 32'd1, 5'd9);
      n = 0;
      while (!wb_valid && n < 60) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, 40);
      check("timeout_exc", wb_exception, 1);
      check("timeout_data", wb_data, 0);
      check("timeout_rd", wb_rd, 9);
      handshake();

      // Asynchronous reset mid-RUN
      start_op(1'b1, 32'd100, 32'd7, 5'd3);
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_busy", {busy, busy_rd}, 6'd0);
      check("arst_wb", {wb_valid, wb_rd, wb_exception, wb_data}, 39'd0);
      check("arst_md", {md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB}, 66'd0);
      check("arst_issue_ready", issue_ready, 1);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      check("post_rst_ready", issue_ready, 1);
      check("post_rst_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_multdiv_sequencer
`default_nettype wire
